// File: rtl/data_sync_tx_if.sv
// ---------------------------------------------------------------------------
// data_sync_tx_if
// Purpose : Bundles the word handshake and the CDC req/ack signals of the
//           source-side bus launcher data_sync_tx.
// Signals : tx_data    word offered by the producer
//           tx_valid   tx_data is valid
//           tx_ready   launcher can accept a word
//           unsync_bus registered word driven toward the destination
//           bus_enable request level toward the destination synchronizer
//           ack_async  acknowledge level from the destination clock domain
//           xfer_done  one-cycle pulse when the destination acknowledged
//           busy       launcher is not idle
// Modports: slave  - the launcher itself
//           master - the producer / destination model side
// ---------------------------------------------------------------------------
interface data_sync_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 ack_async;
  logic                 xfer_done;
  logic                 busy;

  modport slave (
    input  tx_data, tx_valid, ack_async,
    output tx_ready, unsync_bus, bus_enable, xfer_done, busy
  );

  modport master (
    output tx_data, tx_valid, ack_async,
    input  tx_ready, unsync_bus, bus_enable, xfer_done, busy
  );
endinterface

// File: rtl/data_sync_tx.sv
// ---------------------------------------------------------------------------
// data_sync_tx
// Purpose : Source-domain launcher for a multi-bit CDC transfer. A word
//           accepted on the valid/ready handshake is registered onto
//           unsync_bus and held stable while bus_enable is raised; a 4-phase
//           req/ack handshake with the destination completes the transfer,
//           followed by an enable-low gap before the next word is accepted.
// Ports   : i_clk    source-domain clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           bus      data_sync_tx_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module data_sync_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int MIN_GAP    = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  data_sync_tx_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  // Counter must hold MIN_GAP-1; sized on MIN_GAP+1 so MIN_GAP=1 still gets a bit.
  localparam int               GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [1:0]            r_state;
  logic [BUS_WIDTH-1:0]  r_unsync_bus;
  logic                  r_bus_enable;
  logic                  r_xfer_done;
  logic [NUM_STAGES-1:0] r_ack_sync;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  w_ack_sync;

  assign w_ack_sync = r_ack_sync[NUM_STAGES-1];

  // Ack synchronizer chain: the FSM only ever looks at the last stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], bus.ack_async};
    end
  end

  // Transfer FSM. unsync_bus is loaded only in IDLE, so it cannot move while
  // bus_enable is high. An ack already high on entering REQ is accepted as-is.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_unsync_bus <= '0;
      r_bus_enable <= 1'b0;
      r_xfer_done  <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_xfer_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            r_unsync_bus <= bus.tx_data;
            r_bus_enable <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack_sync) begin
            r_bus_enable <= 1'b0;
            r_xfer_done  <= 1'b1;
            r_state      <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!w_ack_sync) begin
            r_gap_cnt <= GAP_LOAD;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_ready   = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.unsync_bus = r_unsync_bus;
  assign bus.bus_enable = r_bus_enable;
  assign bus.xfer_done  = r_xfer_done;

endmodule
